// File: rtl/turbo_encoder_if.sv
// turbo_encoder_if: info-bit input and encoded-step output handshakes.
// master = bit source / channel side, slave = turbo_encoder.
interface turbo_encoder_if;
  logic in_valid_i;
  logic in_bit_i;
  logic in_ready_o;
  logic out_valid_o;
  logic out_ready_i;
  logic sys_o;
  logic par1_o;
  logic sys2_o;
  logic par2_o;
  logic out_last_o;

  modport master (
    output in_valid_i, in_bit_i, out_ready_i,
    input  in_ready_o, out_valid_o, sys_o,
    input  par1_o, sys2_o, par2_o, out_last_o
  );

  modport slave (
    input  in_valid_i, in_bit_i, out_ready_i,
    output in_ready_o, out_valid_o, sys_o,
    output par1_o, sys2_o, par2_o, out_last_o
  );
endinterface

// File: rtl/turbo_encoder.sv
// turbo_encoder: rate-1/3 PCCC encoder, two 4-state RSC (7,5) codes,
// second fed via pi(k) = STEP*k mod BLOCK_SIZE.
// Ports: clk_p_i, reset_p_i (sync, active-high), io (slave modport):
//   in_valid_i/in_bit_i/in_ready_o load one block of info bits;
//   out_valid_o/out_ready_i carry sys_o, par1_o, sys2_o, par2_o,
//   out_last_o per step.
// TURBO_TAIL_EN defined: 2 termination beats drive both encoders to 0.
module turbo_encoder #(
  parameter int BLOCK_SIZE = 21,
  parameter int INTLV_STEP = 8,
  parameter int CNT_W      = 5
) (
  input logic           clk_p_i,
  input logic           reset_p_i,
  turbo_encoder_if.slave io
);

  typedef enum logic [1:0] {
    LOAD,
    ENCODE,
    TAIL
  } state_t;

  localparam logic [CNT_W-1:0] K_LAST =
    CNT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W:0] BS_W =
    (CNT_W+1)'(BLOCK_SIZE);
  localparam logic [CNT_W:0] STEP_W =
    (CNT_W+1)'(INTLV_STEP);
`ifdef TURBO_TAIL_EN
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(1);
`endif

  state_t                r_state;
  state_t                w_next;
  logic [BLOCK_SIZE-1:0] r_buf;
  logic [CNT_W-1:0]      r_wcnt;
  logic [CNT_W-1:0]      r_k;
  logic [CNT_W-1:0]      r_p;
  logic [1:0]            r_s1;
  logic [1:0]            r_s2;

  logic             w_valid;
  logic             w_ready;
  logic             w_fire_in;
  logic             w_fire_out;
  logic             w_wlast;
  logic             w_klast;
  logic             w_end;
  logic             w_u1;
  logic             w_u2;
  logic             w_a1;
  logic             w_a2;
  logic [1:0]       w_ns1;
  logic [1:0]       w_ns2;
  logic [CNT_W:0]   w_psum;
  logic [CNT_W-1:0] w_pnext;

  assign w_ready = (r_state == LOAD) && !reset_p_i;
  assign w_valid = (r_state != LOAD) && !reset_p_i;
  assign w_fire_in  = w_ready && io.in_valid_i;
  assign w_fire_out = w_valid && io.out_ready_i;
  assign w_wlast = (r_wcnt == K_LAST);
  assign w_klast = (r_k == K_LAST);

`ifdef TURBO_TAIL_EN
  assign w_end = (r_state == TAIL) && (r_k == T_LAST);
`else
  assign w_end = (r_state == ENCODE) && w_klast;
`endif

  // Tail input d1^d2 cancels the feedback so a = 0.
  always_comb begin
    w_u1 = 1'b0;
    w_u2 = 1'b0;
    unique case (1'b1)
      (r_state == ENCODE): begin
        w_u1 = r_buf[r_k];
        w_u2 = r_buf[r_p];
      end
      (r_state == TAIL): begin
        w_u1 = r_s1[1] ^ r_s1[0];
        w_u2 = r_s2[1] ^ r_s2[0];
      end
      default: ;
    endcase
  end

  assign w_a1  = w_u1 ^ r_s1[1] ^ r_s1[0];
  assign w_a2  = w_u2 ^ r_s2[1] ^ r_s2[0];
  assign w_ns1 = {w_a1, r_s1[1]};
  assign w_ns2 = {w_a2, r_s2[1]};

  // Modular stride step: one add, at most one subtract.
  assign w_psum  = {1'b0, r_p} + STEP_W;
  assign w_pnext = (w_psum >= BS_W) ?
    CNT_W'(w_psum - BS_W) : CNT_W'(w_psum);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:
        if (w_fire_in && w_wlast) w_next = ENCODE;
      ENCODE:
        if (w_fire_out && w_klast) begin
`ifdef TURBO_TAIL_EN
          w_next = TAIL;
`else
          w_next = LOAD;
`endif
        end
      TAIL:
        if (w_fire_out && w_end) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      r_state <= LOAD;
      r_buf   <= '0;
      r_wcnt  <= '0;
      r_k     <= '0;
      r_p     <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
    end else begin
      r_state <= w_next;
      if (w_fire_in) begin
        r_buf[r_wcnt] <= io.in_bit_i;
        if (w_wlast) begin
          r_wcnt <= '0;
          r_k    <= '0;
          r_p    <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
      if (w_fire_out) begin
        if (w_end) begin
          r_s1 <= '0;
          r_s2 <= '0;
          r_k  <= '0;
          r_p  <= '0;
`ifdef TURBO_TAIL_EN
        end else if (w_klast &&
                     r_state == ENCODE) begin
          // Trellis states carry into the tail.
          r_s1 <= w_ns1;
          r_s2 <= w_ns2;
          r_k  <= '0;
          r_p  <= '0;
`endif
        end else begin
          r_s1 <= w_ns1;
          r_s2 <= w_ns2;
          r_k  <= r_k + 1'b1;
          r_p  <= w_pnext;
        end
      end
    end
  end

  assign io.in_ready_o  = w_ready;
  assign io.out_valid_o = w_valid;
  assign io.sys_o       = w_valid & w_u1;
  assign io.sys2_o      = w_valid & w_u2;
  assign io.par1_o      = w_valid & (w_a1 ^ r_s1[0]);
  assign io.par2_o      = w_valid & (w_a2 ^ r_s2[0]);
  assign io.out_last_o  = w_valid & w_end;

endmodule

// File: tb/tb_turbo_encoder.sv
// tb_turbo_encoder: directed + random-backpressure check of
// turbo_encoder against a behavioural PCCC model.
module tb_turbo_encoder;
  localparam int BS   = 21;
  localparam int STEP = 8;
`ifdef TURBO_TAIL_EN
  localparam int NB = BS + 2;
`else
  localparam int NB = BS;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int beats_done = 0;
  bit bp_mode = 1'b0;

  logic [4:0] mb [0:BS+1];
  int nb = 0;
  logic [4:0] expq [$];
  logic [4:0] prev_got = '0;
  bit prev_stall = 1'b0;

  turbo_encoder_if ifc ();

  turbo_encoder dut (
    .clk_p_i  (clk),
    .reset_p_i(rst),
    .io       (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  // Beat word: {sys, par1, sys2, par2, last}
  function automatic void model(input logic [BS-1:0] b);
    logic [1:0] s1, s2;
    logic u1, u2, a1, a2;
    s1 = 2'b00;
    s2 = 2'b00;
    for (int k = 0; k < NB; k++) begin
      if (k < BS) begin
        u1 = b[k];
        u2 = b[(STEP * k) % BS];
      end else begin
        u1 = s1[1] ^ s1[0];
        u2 = s2[1] ^ s2[0];
      end
      a1 = u1 ^ s1[1] ^ s1[0];
      a2 = u2 ^ s2[1] ^ s2[0];
      mb[k] = {u1, a1 ^ s1[0], u2, a2 ^ s2[0],
               (k == NB - 1) ? 1'b1 : 1'b0};
      s1 = {a1, s1[1]};
      s2 = {a2, s2[1]};
    end
    nb = NB;
  endfunction

  function automatic logic [BS-1:0] col(input int bitpos);
    logic [BS-1:0] v;
    for (int k = 0; k < BS; k++) v[k] = mb[k][bitpos];
    return v;
  endfunction

  task automatic push_model(input logic [BS-1:0] b);
    model(b);
    for (int i = 0; i < nb; i++) expq.push_back(mb[i]);
  endtask

  task automatic feed(input logic [BS-1:0] b);
    int i = 0;
    int t = 0;
    while (i < BS && t < 2000) begin
      ifc.in_valid_i = 1'b1;
      ifc.in_bit_i   = b[i];
      @(negedge clk);
      if (ifc.in_ready_o) i++;
      @(posedge clk);
      #1;
      t++;
    end
    ifc.in_valid_i = 1'b0;
    ifc.in_bit_i   = 1'b0;
    if (i < BS) chk("feed_timeout", 32'(i), 32'(BS));
  endtask

  task automatic send(input logic [BS-1:0] b);
    push_model(b);
    feed(b);
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (expq.size() != 0)
      chk("drain_timeout", 32'(expq.size()), 0);
  endtask

  // out_ready driver
  initial begin
    ifc.out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.out_ready_i = bp_mode ?
        1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process
  always @(negedge clk) begin
    logic [4:0] got;
    got = {ifc.sys_o, ifc.par1_o, ifc.sys2_o,
           ifc.par2_o, ifc.out_last_o};
    if (rst) begin
      prev_stall = 1'b0;
      chk("rst_hs", {30'd0, ifc.in_ready_o,
          ifc.out_valid_o}, 0);
      chk("rst_data", 32'(got), 0);
    end else begin
      if (ifc.in_ready_o && ifc.out_valid_o)
        chk("single_buf", 1, 0);
      if (ifc.out_valid_o) begin
        if (prev_stall) chk("stall_hold", 32'(got),
                            32'(prev_got));
        if (expq.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("beat", 32'(got), 32'(expq[0]));
          if (ifc.out_ready_i) begin
            void'(expq.pop_front());
            beats_done++;
          end
        end
        prev_stall = !ifc.out_ready_i;
        prev_got   = got;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    logic [BS-1:0] rb;
    int base;
    int t;
    ifc.in_valid_i = 1'b0;
    ifc.in_bit_i   = 1'b0;

    // Pin the model with hand-derived values.
    model(21'h000001);
    chk("pin_par1_imp", 32'(col(3)), 32'h1B6DB7);
    chk("pin_par2_imp", 32'(col(1)), 32'h1B6DB7);
    chk("pin_sys_imp",  32'(col(4)), 32'h1);
`ifdef TURBO_TAIL_EN
    chk("pin_tail0", 32'(mb[BS]), 32'b11110);
    chk("pin_tail1", 32'(mb[BS+1]), 32'b00001);
`else
    chk("pin_last", 32'(mb[BS-1][0]), 1);
`endif
    model(21'h000100);
    chk("pin_sys2_8", 32'(col(2)), 32'h2);
    chk("pin_par1_lo", 32'(col(3) & 21'hFF), 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ifc.in_ready_o), 1);
    chk("post_rst_valid", 32'(ifc.out_valid_o), 0);
    @(posedge clk);
    #1;

    send(21'h000000);
    send(21'h000001);
    send(21'h000100);
    drain();
    @(negedge clk);
    chk("idle_ready", 32'(ifc.in_ready_o), 1);
    @(posedge clk);
    #1;

    // Reset at ENCODE k = 10.
    base = beats_done;
    send(21'h15A3C7);
    t = 0;
    while (beats_done < base + 10 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (beats_done < base + 10)
      chk("k10_timeout", 32'(beats_done - base), 10);
    rst = 1'b1;
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(ifc.in_ready_o), 1);
    chk("mid_rst_valid", 32'(ifc.out_valid_o), 0);
    @(posedge clk);
    #1;
    base = beats_done;
    send(21'h1FFFFF);
    drain();
    chk("ones_beats", 32'(beats_done - base), 32'(NB));

    bp_mode = 1'b1;
    for (int n = 0; n < 100; n++) begin
      rb = BS'($urandom);
      send(rb);
    end
    drain();
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_ready", 32'(ifc.in_ready_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
